fp_unpacker: RTL and testbench

//  Operand-side counterpart of the rounder: takes a packed IEEE-754 single or double and splits it

---
 rtl/fp_unpacker.sv | 153 +++++++++++++++
 tb/tb_fp_unpacker.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_unpacker.sv
// Splits a packed IEEE-754 single/double operand into sign, 13-bit biased exponent and
// 53-bit significand with class flags; denormals are normalized a few bits per cycle.
module fp_unpacker #(
  parameter int SHIFT_STEP = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               db,
  input  logic [63:0]        fa,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               s,
  output logic signed [12:0] e,
  output logic [52:0]        f,
  output logic [5:0]         lz,
  output logic               is_zero,
  output logic               is_inf,
  output logic               is_nan,
  output logic               is_snan,
  output logic               is_denorm
);

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  // Field split; single fractions are left-aligned so both formats share one datapath.
  logic        sgn;
  logic [10:0] ex;
  logic [51:0] fr;
  logic        ex_zero;
  logic        ex_ones;
  logic        fr_zero;
  logic        fr_msb;
  logic [4:0]  nz;

  function automatic logic [4:0] lead_zeros(input logic [52:0] v);
    logic [4:0] n;
    logic       found;
    n     = STEP;
    found = 1'b0;
    for (int i = 0; i < SHIFT_STEP; i++) begin
      if (!found && v[52-i]) begin
        n     = 5'(i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  always_comb begin
    sgn = fa[63];
    if (db) begin
      ex      = fa[62:52];
      fr      = fa[51:0];
      ex_ones = &fa[62:52];
      fr_msb  = fa[51];
    end else begin
      ex      = {3'b000, fa[62:55]};
      fr      = {fa[54:32], 29'd0};
      ex_ones = &fa[62:55];
      fr_msb  = fa[54];
    end
    ex_zero = (ex == 11'd0);
    fr_zero = (fr == 52'd0);
  end

  assign nz       = lead_zeros(f);
  assign in_ready = rst_n && (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      s         <= 1'b0;
      e         <= '0;
      f         <= '0;
      lz        <= '0;
      is_zero   <= 1'b0;
      is_inf    <= 1'b0;
      is_nan    <= 1'b0;
      is_snan   <= 1'b0;
      is_denorm <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            s         <= sgn;
            lz        <= '0;
            e         <= signed'({2'b00, ex});
            is_zero   <= 1'b0;
            is_inf    <= 1'b0;
            is_nan    <= 1'b0;
            is_snan   <= 1'b0;
            is_denorm <= 1'b0;
            if (ex_zero && fr_zero) begin
              is_zero   <= 1'b1;
              e         <= '0;
              f         <= '0;
              state     <= DONE;
              out_valid <= 1'b1;
            end else if (ex_ones) begin
              is_inf    <= fr_zero;
              is_nan    <= !fr_zero;
              is_snan   <= !fr_zero && !fr_msb;
              f         <= {1'b0, fr};
              state     <= DONE;
              out_valid <= 1'b1;
            end else if (ex_zero) begin
              // Denormal: effective exponent is 1, hidden bit is 0.
              is_denorm <= 1'b1;
              e         <= 13'sd1;
              f         <= {1'b0, fr};
              state     <= NORM;
            end else begin
              f         <= {1'b1, fr};
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end
        NORM: begin
          f  <= f << nz;
          lz <= lz + 6'(nz);
          e  <= e - signed'({8'd0, nz});
          if (nz < STEP) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_unpacker.sv
// Scoreboard bench for fp_unpacker: a reference model computes expected fields and latency
// at accept time; a negedge monitor pops and compares on every output handshake.
module tb_fp_unpacker;

  localparam int SHIFT_STEP = 8;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        db;
  logic [63:0] fa;
  logic        out_valid;
  logic        out_ready;
  logic        s;
  logic [12:0] e;
  logic [52:0] f;
  logic [5:0]  lz;
  logic        is_zero, is_inf, is_nan, is_snan, is_denorm;

  typedef struct packed {
    logic        s;
    logic [12:0] e;
    logic [52:0] f;
    logic [5:0]  lz;
    logic [4:0]  flags;
    logic [7:0]  lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk;
  int   n_err;
  int   cyc;
  int   acc_cyc;
  int   first_cyc;
  bit   seen_valid;

  fp_unpacker #(.SHIFT_STEP(SHIFT_STEP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .db(db), .fa(fa),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .e(e), .f(f), .lz(lz),
    .is_zero(is_zero), .is_inf(is_inf), .is_nan(is_nan), .is_snan(is_snan), .is_denorm(is_denorm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input logic dbl, input logic [63:0] a);
    exp_t        r;
    logic [10:0] x;
    logic [51:0] m;
    logic        all1;
    int          z;
    r   = '0;
    r.s = a[63];
    if (dbl) begin
      x    = a[62:52];
      m    = a[51:0];
      all1 = (x == 11'h7FF);
    end else begin
      x    = {3'b000, a[62:55]};
      m    = {a[54:32], 29'd0};
      all1 = (x == 11'h0FF);
    end
    r.lat = 8'd1;
    if (x == 0 && m == 0) begin
      r.flags = 5'b10000;
    end else if (all1) begin
      r.e = {2'b00, x};
      r.f = {1'b0, m};
      if (m == 0) r.flags = 5'b01000;
      else        r.flags = {2'b00, 1'b1, ~m[51], 1'b0};
    end else if (x == 0) begin
      r.f = {1'b0, m};
      z   = 0;
      while (!r.f[52]) begin
        r.f = r.f << 1;
        z++;
      end
      r.lz    = 6'(z);
      r.e     = 13'(1 - z);
      r.flags = 5'b00001;
      r.lat   = 8'(z / SHIFT_STEP + 2);
    end else begin
      r.e = {2'b00, x};
      r.f = {1'b1, m};
    end
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t x;
    if (!rst_n) begin
      seen_valid = 1'b0;
    end else begin
      if (out_valid && !seen_valid) begin
        seen_valid = 1'b1;
        first_cyc  = cyc;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 64'd1, 64'd0);
        end else begin
          x = exp_q.pop_front();
          chk("sign", s, x.s);
          chk("exp", e, x.e);
          chk("frac", f, x.f);
          chk("lz", lz, x.lz);
          chk("flags", {is_zero, is_inf, is_nan, is_snan, is_denorm}, x.flags);
          chk("latency", 64'(first_cyc - acc_cyc + 1), 64'(x.lat));
        end
        seen_valid = 1'b0;
      end
    end
  end

  task automatic send(input logic d, input logic [63:0] a);
    int n;
    n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    db       = d;
    fa       = a;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
    end else begin
      exp_q.push_back(model(d, a));
      acc_cyc = cyc + 1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    db       = 1'($urandom);
    fa       = {$urandom, $urandom};
  endtask

  task automatic drain(input bit rnd);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      @(posedge clk); #1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (out_valid && out_ready) done = 1'b1;
      n++;
    end
    if (!done) chk("drain_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run(input logic d, input logic [63:0] a, input bit rnd);
    send(d, a);
    drain(rnd);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r64;
    logic [63:0] op;
    logic [24:0] snap_a;
    logic [52:0] snap_f;
    logic        d;
    int          sel;
    int          n;
    n_chk     = 0;
    n_err     = 0;
    cyc       = 0;
    acc_cyc   = 0;
    first_cyc = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    db        = 1'b0;
    fa        = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", {s, e, lz, is_zero, is_inf, is_nan, is_snan, is_denorm}, 0);
    chk("rst_frac", f, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", in_ready, 1);

    // Directed operands with spec-given constants.
    run(1'b1, 64'h4008000000000000, 1'b0);
    chk("t1_e", e, 13'h400);
    chk("t1_f", f, 53'h18000000000000);
    chk("t1_flags", {lz, is_zero, is_inf, is_nan, is_snan, is_denorm}, 0);

    run(1'b1, 64'h0000000000000001, 1'b0);
    chk("t2_e", e, 13'h1FCD);
    chk("t2_f", f, 53'h10000000000000);
    chk("t2_lz", lz, 52);
    chk("t2_denorm", is_denorm, 1);

    run(1'b0, 64'h7FC00000_00000000, 1'b0);
    chk("t3_qnan", {is_nan, is_snan}, 2'b10);
    run(1'b0, 64'h7F800001_00000000, 1'b0);
    chk("t3_snan", {is_nan, is_snan}, 2'b11);
    run(1'b0, 64'hFF800000_00000000, 1'b0);
    chk("t3_inf", {s, is_inf, e, f}, {1'b1, 1'b1, 13'h0FF, 53'd0});

    run(1'b1, 64'h8000000000000000, 1'b0);
    chk("t6_zero", {s, is_zero, e, f, lz}, {1'b1, 1'b1, 13'd0, 53'd0, 6'd0});

    run(1'b0, 64'h00000000_FFFFFFFF, 1'b0);
    run(1'b0, 64'h00000001_00000000, 1'b0);
    run(1'b0, 64'h80400000_00000000, 1'b0);
    run(1'b0, 64'h3F800000_12345678, 1'b0);
    run(1'b1, 64'h0008000000000000, 1'b0);
    run(1'b1, 64'h0000100000000000, 1'b0);
    run(1'b1, 64'h7FF0000000000000, 1'b0);
    run(1'b1, 64'h7FF0000000000001, 1'b0);
    run(1'b1, 64'hFFF8000000000000, 1'b0);
    run(1'b1, 64'h000FFFFFFFFFFFFF, 1'b0);

    // Backpressure: outputs hold while out_ready stays low.
    send(1'b0, 64'h3FC00000_00000000);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    snap_a = {s, e, lz, is_zero, is_inf, is_nan, is_snan, is_denorm};
    snap_f = f;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold", {s, e, lz, is_zero, is_inf, is_nan, is_snan, is_denorm}, snap_a);
      chk("bp_hold_f", f, snap_f);
    end
    drain(1'b0);
    @(negedge clk);
    chk("ready_after_hs", in_ready, 1);
    chk("valid_drop", out_valid, 0);

    // Reset in the third normalization cycle abandons the operand.
    send(1'b1, 64'h0000000000000001);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    exp_q.delete();
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_outputs", {s, e, lz, is_zero, is_inf, is_nan, is_snan, is_denorm}, 0);
    chk("midrst_frac", f, 0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_release_ready", in_ready, 1);
    repeat (12) begin
      @(negedge clk);
      chk("no_stale_valid", out_valid, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Random operands with random consumer stalls.
    for (int k = 0; k < 60; k++) begin
      r64 = {$urandom, $urandom};
      d   = 1'($urandom);
      sel = $urandom_range(0, 3);
      op  = r64;
      if (sel == 1) begin
        if (d) op = {r64[63], 11'd0, 52'(r64[51:0] >> $urandom_range(0, 51))};
        else   op = {r64[63], 8'd0, 23'(r64[54:32] >> $urandom_range(0, 22)), r64[31:0]};
      end else if (sel == 2) begin
        if (d) op = {r64[63], 11'h7FF, r64[51:0]};
        else   op = {r64[63], 8'hFF, r64[54:0]};
      end
      run(d, op, 1'b1);
    end

    repeat (3) @(negedge clk);
    chk("pending", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
